// File: rtl/circuito_serializador_if.sv
// Parallel-load / serial-out bus of the 4-bit serializer.
// cargar acts as valid and !ocupado as ready: a word transfers on the rising edge where both are high.
// listo pulses for one cycle after a frame's stop bit.
interface circuito_serializador_if;
  logic [3:0] entradas;
  logic       cargar;
  logic       serie;
  logic       ocupado;
  logic       listo;

  modport master (
    output entradas,
    output cargar,
    input  serie,
    input  ocupado,
    input  listo
  );

  modport slave (
    input  entradas,
    input  cargar,
    output serie,
    output ocupado,
    output listo
  );
endinterface

// File: rtl/circuito_serializador.sv
// Transmits a 4-bit word as a start(0) / 4 data (LSB first) / stop(1) frame.
// Each bit lasts DIV clock cycles, and all outputs are registered.
module circuito_serializador #(
  parameter int DIV = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  circuito_serializador_if.slave         bus,
  output logic [1:0]                     estado
);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    INICIO = 2'd1,
    DATOS  = 2'd2,
    PARADA = 2'd3
  } estado_t;

  localparam logic [3:0] CNT_MAX = 4'(DIV - 1);

  estado_t    st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] sr_q, sr_d;
  logic [1:0] bit_q, bit_d;
  logic       serie_q, serie_d;
  logic       ocup_q, ocup_d;
  logic       listo_q, listo_d;
  logic       fin_bit;

  assign fin_bit     = (cnt_q == CNT_MAX);
  assign bus.serie   = serie_q;
  assign bus.ocupado = ocup_q;
  assign bus.listo   = listo_q;
  assign estado      = st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= REPOSO;
      cnt_q   <= 4'd0;
      sr_q    <= 4'd0;
      bit_q   <= 2'd0;
      serie_q <= 1'b1;
      ocup_q  <= 1'b0;
      listo_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      serie_q <= serie_d;
      ocup_q  <= ocup_d;
      listo_q <= listo_d;
    end
  end

  // Next-state logic also computes next outputs so the line is glitch-free.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    serie_d = serie_q;
    ocup_d  = ocup_q;
    listo_d = 1'b0;
    case (st_q)
      REPOSO: begin
        serie_d = 1'b1;
        ocup_d  = 1'b0;
        cnt_d   = 4'd0;
        bit_d   = 2'd0;
        if (bus.cargar) begin
          sr_d    = bus.entradas;
          st_d    = INICIO;
          serie_d = 1'b0;
          ocup_d  = 1'b1;
        end
      end
      INICIO: begin
        if (fin_bit) begin
          cnt_d   = 4'd0;
          st_d    = DATOS;
          serie_d = sr_q[0];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DATOS: begin
        if (fin_bit) begin
          cnt_d = 4'd0;
          bit_d = bit_q + 2'd1;
          sr_d  = {1'b0, sr_q[3:1]};
          // The bit counter wraps 3->0 exactly as the frame enters the stop bit.
          if (bit_q == 2'd3) begin
            st_d    = PARADA;
            serie_d = 1'b1;
          end else begin
            serie_d = sr_q[1];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PARADA: begin
        if (fin_bit) begin
          cnt_d   = 4'd0;
          st_d    = REPOSO;
          serie_d = 1'b1;
          ocup_d  = 1'b0;
          listo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        st_d    = REPOSO;
        cnt_d   = 4'd0;
        bit_d   = 2'd0;
        serie_d = 1'b1;
        ocup_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_circuito_serializador.sv
// Directed bench for circuito_serializador at DIV = 2, 1 and 16.
// Expected serial bits come from a small frame model queued per cycle.
module tb_circuito_serializador;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // clock/reset block
  always #5 clk = ~clk;

  circuito_serializador_if bus2 ();
  circuito_serializador_if bus1 ();
  circuito_serializador_if bus16 ();

  logic [1:0] est2, est1, est16;

  circuito_serializador #(.DIV(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2),  .estado(est2));
  circuito_serializador #(.DIV(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1),  .estado(est1));
  circuito_serializador #(.DIV(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16), .estado(est16));

  logic       cargar_v [3];
  logic [3:0] ent_v [3];
  int         sel;

  assign bus2.cargar    = cargar_v[0];
  assign bus2.entradas  = ent_v[0];
  assign bus1.cargar    = cargar_v[1];
  assign bus1.entradas  = ent_v[1];
  assign bus16.cargar   = cargar_v[2];
  assign bus16.entradas = ent_v[2];

  logic       serie_s, ocup_s, listo_s;
  logic [1:0] est_s;

  always_comb begin
    serie_s = bus2.serie;
    ocup_s  = bus2.ocupado;
    listo_s = bus2.listo;
    est_s   = est2;
    case (sel)
      1: begin
        serie_s = bus1.serie;
        ocup_s  = bus1.ocupado;
        listo_s = bus1.listo;
        est_s   = est1;
      end
      2: begin
        serie_s = bus16.serie;
        ocup_s  = bus16.ocupado;
        listo_s = bus16.listo;
        est_s   = est16;
      end
      default: ;
    endcase
  end

  // scoreboard
  int         n_vec = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [3:0] v, input int k);
    if (k == 0) return 1'b0;
    if (k == 5) return 1'b1;
    return v[k-1];
  endfunction

  // driver tasks: called just after a falling edge
  task automatic load(input int s, input logic [3:0] val, input bit hold);
    cargar_v[s] = 1'b1;
    ent_v[s]    = val;
    @(posedge clk);
    #1;
    if (!hold) cargar_v[s] = 1'b0;
  endtask

  task automatic idle_chk(input int s, input int n);
    sel = s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_serie", 32'(serie_s), 32'd1);
      chk("idle_ocupado", 32'(ocup_s), 32'd0);
      chk("idle_listo", 32'(listo_s), 32'd0);
    end
  endtask

  // Checks a frame whose load edge has just passed; inj>0 pokes cargar/entradas mid-frame.
  task automatic frame_chk(input int s, input int div, input logic [3:0] val, input int inj);
    sel = s;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < div; j++)
        exp_q.push_back(exp_bit(val, k));
    for (int c = 1; c <= 6 * div; c++) begin
      @(negedge clk);
      chk("serie", 32'(serie_s), 32'(exp_q.pop_front()));
      chk("ocupado", 32'(ocup_s), 32'd1);
      chk("listo_early", 32'(listo_s), 32'd0);
      if (inj != 0 && c == inj) begin
        cargar_v[s] = 1'b1;
        ent_v[s]    = 4'd5;
      end
      if (inj != 0 && c == inj + 1) cargar_v[s] = 1'b0;
    end
    @(negedge clk);
    chk("listo_pulse", 32'(listo_s), 32'd1);
    chk("ocupado_end", 32'(ocup_s), 32'd0);
    chk("serie_end", 32'(serie_s), 32'd1);
  endtask

  initial begin
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      cargar_v[i] = 1'b0;
      ent_v[i]    = 4'd0;
    end

    // Reset values on every instance
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_serie", 32'(serie_s), 32'd1);
      chk("rst_ocupado", 32'(ocup_s), 32'd0);
      chk("rst_listo", 32'(listo_s), 32'd0);
      chk("rst_estado", 32'(est_s), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk(0, 2);

    // Single frame, 9 -> 0,0,1,1,0,0,0,0,1,1,1,1
    load(0, 4'd9, 1'b0);
    frame_chk(0, 2, 4'd9, 0);
    idle_chk(0, 2);

    // Mid-frame load of 5 must be ignored and not queue a second frame
    load(0, 4'd9, 1'b0);
    frame_chk(0, 2, 4'd9, 4);
    idle_chk(0, 6);

    // cargar held high: back-to-back frames with one listo cycle between
    load(0, 4'd4, 1'b1);
    frame_chk(0, 2, 4'd4, 0);
    frame_chk(0, 2, 4'd4, 0);
    frame_chk(0, 2, 4'd4, 0);
    cargar_v[0] = 1'b0;
    idle_chk(0, 3);

    // Asynchronous reset in the middle of the data bits
    load(0, 4'd9, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sel = 0;
    chk("async_serie", 32'(serie_s), 32'd1);
    chk("async_ocupado", 32'(ocup_s), 32'd0);
    chk("async_listo", 32'(listo_s), 32'd0);
    chk("async_estado", 32'(est_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk(0, 14);
    load(0, 4'd6, 1'b0);
    frame_chk(0, 2, 4'd6, 0);
    idle_chk(0, 2);

    // DIV=1, 15 -> 0,1,1,1,1,1 then listo on cycle 7
    load(1, 4'd15, 1'b0);
    frame_chk(1, 1, 4'd15, 0);
    idle_chk(1, 2);

    // DIV=16, 0 -> 80 low cycles, 16 high, 96 cycles busy
    load(2, 4'd0, 1'b0);
    frame_chk(2, 16, 4'd0, 0);
    idle_chk(2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
